// File: rtl/req_capture_pkg.sv
// req_capture_pkg: shared defaults and FSM state type for the request capture stage.
//   NREQ_DEF  - default number of request lines (index 0 = highest priority)
//   IDXW_DEF  - default index width (2**IDXW_DEF > NREQ_DEF)
//   state_e   - dispatch FSM states
package req_capture_pkg;

  localparam int unsigned NREQ_DEF = 15;
  localparam int unsigned IDXW_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_PRESENT
  } state_e;

endpackage

// File: rtl/req_capture_lowest_set_index.sv
// lowest_set_index: combinational lowest-set-bit finder, bit 0 has priority.
//   bits_i  in  NREQ  vector to search
//   idx_o   out IDXW  index of the lowest set bit (0 when none set)
//   any_o   out 1     at least one bit of bits_i is set
module lowest_set_index #(
  parameter int unsigned NREQ = 15,
  parameter int unsigned IDXW = 4
) (
  input  logic [NREQ-1:0] bits_i,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  // Scan from the top down so the last hit, the lowest index, is what remains.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (bits_i[i]) begin
        idx_o = IDXW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_capture.sv
// req_capture: latches events on NREQ request lines into a pending register and
// dispatches the lowest-numbered pending request as an index over valid/ready.
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous active-high reset
//   req_in     in   NREQ  raw request lines
//   out_valid  out  1     out_idx holds a granted request
//   out_ready  in   1     consumer accepts out_idx this cycle
//   out_idx    out  IDXW  index of granted request
//   pending    out  NREQ  registered pending-request bits
//   overflow   out  1     one-cycle pulse: new event hit an already-pending bit
//
// Build option:
//   EDGE_DETECT_EN  defined   -> rising-edge capture through req_d, overflow active
//                   undefined -> level capture, no req_d, overflow tied low
//
// All outputs come straight from flops; selection uses the registered pending
// value, so an event captured this cycle is eligible for grant next cycle.
module req_capture
  import req_capture_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic [NREQ-1:0] pending,
  output logic            overflow
);

  state_e          state_q;
  logic            out_valid_q;
  logic [IDXW-1:0] out_idx_q;
  logic [NREQ-1:0] pending_q;
  logic [NREQ-1:0] pending_d;
  logic            overflow_q;
  logic            overflow_d;

  logic [NREQ-1:0] set_ev;
  logic [NREQ-1:0] clr;
  logic [IDXW-1:0] sel_idx;
  logic            sel_any;
  logic            load;

  lowest_set_index #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_lowest_set_index (
    .bits_i (pending_q),
    .idx_o  (sel_idx),
    .any_o  (sel_any)
  );

`ifdef EDGE_DETECT_EN
  logic [NREQ-1:0] req_d_q;

  // Cleared on reset so a line held high through reset is captured once after.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d_q <= '0;
    end else begin
      req_d_q <= req_in;
    end
  end

  assign set_ev     = req_in & ~req_d_q;
  // Duplicate edge on a bit that stays pending: event is dropped, flag it.
  assign overflow_d = |(set_ev & pending_q & ~clr);
`else
  // A held line re-requests every cycle by design, so there is nothing to flag.
  assign set_ev     = req_in;
  assign overflow_d = 1'b0;
`endif

  // A load happens whenever the output slot is free or being freed and
  // something is pending; the loaded bit is cleared in the same cycle.
  always_comb begin
    load = 1'b0;
    case (state_q)
      ST_IDLE:    load = sel_any;
      ST_PRESENT: load = out_ready & sel_any;
      default:    load = 1'b0;
    endcase
    clr       = load ? (NREQ'(1) << sel_idx) : '0;
    // Set is OR-ed last so it wins over a clear of the same bit.
    pending_d = (pending_q & ~clr) | set_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      case (state_q)
        ST_IDLE: begin
          if (sel_any) begin
            out_idx_q   <= sel_idx;
            out_valid_q <= 1'b1;
            state_q     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            if (sel_any) begin
              // Back-to-back reload, no bubble between transfers.
              out_idx_q <= sel_idx;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_req_capture.sv
// Self-checking bench for req_capture. Expected grant indices are queued as
// stimulus is applied and popped by a monitor on every completed transfer;
// cycle-level status checks are made directly in the stimulus thread.
module tb_req_capture;

  localparam int unsigned NREQ = 15;
  localparam int unsigned IDXW = 4;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_in;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;
  logic [NREQ-1:0] pending;
  logic            overflow;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned sb[$];
  logic        exp_ovf;

  req_capture #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted transfer must match the next queued index.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      int unsigned exp_idx;
      if (sb.size() > 0) exp_idx = sb.pop_front();
      else exp_idx = 32'hDEAD;
      check_eq("grant_idx", 32'(out_idx), exp_idx);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
`ifdef EDGE_DETECT_EN
    exp_ovf   = 1'b1;
`else
    exp_ovf   = 1'b0;
`endif
    rst       = 1'b1;
    req_in    = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_idx", 32'(out_idx), 0);
    check_eq("rst_pending", 32'(pending), 0);
    check_eq("rst_overflow", 32'(overflow), 0);

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_valid", 32'(out_valid), 0);
      check_eq("idle_pending", 32'(pending), 0);
      check_eq("idle_overflow", 32'(overflow), 0);
    end

    // Single pulse on line 5: pending after N, output after N+1
    req_in = NREQ'(1) << 5;
    sb.push_back(5);
    tick();
    req_in = '0;
    check_eq("single_pending", 32'(pending), 32'h20);
    check_eq("single_valid_early", 32'(out_valid), 0);
    tick();
    check_eq("single_valid", 32'(out_valid), 1);
    check_eq("single_idx", 32'(out_idx), 5);
    check_eq("single_pending_clr", 32'(pending), 0);
    out_ready = 1'b1;
    tick();
    check_eq("single_done_valid", 32'(out_valid), 0);
    check_eq("single_done_pending", 32'(pending), 0);

    // Priority order with back-to-back transfers
    req_in = (NREQ'(1) << 9) | (NREQ'(1) << 3) | (NREQ'(1) << 12);
    sb.push_back(3);
    sb.push_back(9);
    sb.push_back(12);
    tick();
    req_in = '0;
    tick();
    check_eq("prio_v0", 32'(out_valid), 1);
    check_eq("prio_i0", 32'(out_idx), 3);
    tick();
    check_eq("prio_v1", 32'(out_valid), 1);
    check_eq("prio_i1", 32'(out_idx), 9);
    tick();
    check_eq("prio_v2", 32'(out_valid), 1);
    check_eq("prio_i2", 32'(out_idx), 12);
    tick();
    check_eq("prio_end_valid", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Backpressure: 7 held while a higher-priority request arrives
    req_in = NREQ'(1) << 7;
    sb.push_back(7);
    tick();
    req_in = '0;
    tick();
    req_in = NREQ'(1) << 1;
    sb.push_back(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      req_in = '0;
      check_eq("bp_valid", 32'(out_valid), 1);
      check_eq("bp_idx", 32'(out_idx), 7);
    end
    check_eq("bp_pending", 32'(pending), 32'h2);
    out_ready = 1'b1;
    tick();
    check_eq("bp_next_valid", 32'(out_valid), 1);
    check_eq("bp_next_idx", 32'(out_idx), 1);
    tick();
    check_eq("bp_end_valid", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Duplicate events on a bit that is still pending behind a stalled output
    req_in = NREQ'(1) << 2;
    sb.push_back(2);
    tick();
    req_in = '0;
    tick();
    req_in = NREQ'(1) << 4;
    sb.push_back(4);
    tick();
    req_in = '0;
    check_eq("ovf_first", 32'(overflow), 0);
    tick();
    check_eq("ovf_pending", 32'(pending), 32'h10);
    for (int k = 0; k < 2; k++) begin
      req_in = NREQ'(1) << 4;
      tick();
      req_in = '0;
      check_eq("ovf_pulse", 32'(overflow), 32'(exp_ovf));
      tick();
      check_eq("ovf_clear", 32'(overflow), 0);
    end
    check_eq("ovf_hold_idx", 32'(out_idx), 2);
    out_ready = 1'b1;
    tick();
    check_eq("ovf_grant_valid", 32'(out_valid), 1);
    check_eq("ovf_grant_idx", 32'(out_idx), 4);
    tick();
    check_eq("ovf_end_valid", 32'(out_valid), 0);
    check_eq("ovf_end_pending", 32'(pending), 0);
    out_ready = 1'b0;

    // Reset in the middle of a stalled handshake
    req_in = NREQ'(16'h0A0F);
    tick();
`ifdef EDGE_DETECT_EN
    req_in = NREQ'(1) << 11;
`else
    req_in = '0;
`endif
    tick();
    check_eq("mid_valid", 32'(out_valid), 1);
    check_eq("mid_idx", 32'(out_idx), 0);
    check_eq("mid_pending", 32'(pending), 32'h0A0E);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_valid", 32'(out_valid), 0);
    check_eq("mrst_idx", 32'(out_idx), 0);
    check_eq("mrst_pending", 32'(pending), 0);
    check_eq("mrst_overflow", 32'(overflow), 0);
`ifdef EDGE_DETECT_EN
    // Held line is captured exactly once after reset
    sb.push_back(11);
    tick();
    check_eq("held_pending", 32'(pending), 32'h800);
    tick();
    check_eq("held_valid", 32'(out_valid), 1);
    check_eq("held_idx", 32'(out_idx), 11);
    out_ready = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_valid", 32'(out_valid), 0);
      check_eq("post_pending", 32'(pending), 0);
    end
    req_in    = '0;
    out_ready = 1'b0;
    tick();

    check_eq("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
